gsm_coef_ctrl: RTL and testbench

GSM_COEF_CTRL -- requirements
Module: gsm_coef_ctrl

---
 rtl/gsm_coef_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_gsm_coef_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gsm_coef_ctrl.sv
// Double-banked coefficient store and load/swap controller for the 101-tap
// symmetric GSM channel filter. A host loads NCOEF words into the shadow bank,
// commits, and the banks swap on the next sample strobe. y_valid then stays low
// until FLUSH_LEN strobes (including the swap strobe) have passed, so that
// filter outputs mixing old and new coefficients are flagged invalid.
//
// Handshake: a coefficient word transfers on every sys_clk edge where
// cw_valid and cw_ready are both high. cw_ready depends only on the FSM state,
// never on cw_valid. The sender holds cw_data stable while cw_valid is high.
module gsm_coef_ctrl #(
  parameter int WIDTH     = 18,
  parameter int NCOEF     = 51,
  parameter int FLUSH_LEN = 110
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic                    sam_clk_en,
  input  logic                    load_start,
  input  logic                    cw_valid,
  output logic                    cw_ready,
  input  logic signed [WIDTH-1:0] cw_data,
  input  logic                    commit,
  input  logic [5:0]              coef_rd_addr,
  output logic signed [WIDTH-1:0] coef_rd_data,
  output logic                    bank_sel,
  output logic                    y_valid,
  output logic                    busy,
  output logic                    load_err,
  output logic [2:0]              state_dbg
);

  // Bank index width; the filter-side address port is 6 bits, so NCOEF <= 64.
  localparam int AW = (NCOEF > 1) ? $clog2(NCOEF) : 1;
  localparam int PW = $clog2(NCOEF + 1);
  localparam int FW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam logic [PW-1:0] LAST_PTR   = PW'(NCOEF - 1);
  localparam logic [FW-1:0] FLUSH_INIT = FW'(FLUSH_LEN - 1);
  localparam logic [6:0]    NCOEF_A    = 7'(NCOEF);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    ARMED     = 3'd2,
    SWAP_WAIT = 3'd3,
    FLUSH     = 3'd4
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [PW-1:0]           wr_ptr;
  logic [FW-1:0]           flush_cnt;
  logic signed [WIDTH-1:0] bank0 [NCOEF];
  logic signed [WIDTH-1:0] bank1 [NCOEF];

  logic          ptr_clr;
  logic          word_wr;
  logic          swap;
  logic          flush_done;
  logic          err_set;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          rd_in_range;

  assign wr_idx      = wr_ptr[AW-1:0];
  assign rd_idx      = coef_rd_addr[AW-1:0];
  assign rd_in_range = ({1'b0, coef_rd_addr} < NCOEF_A);

  assign cw_ready  = (state == LOAD);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // State register.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and one-cycle control strobes for the datapath.
  always_comb begin
    state_nxt  = state;
    ptr_clr    = 1'b0;
    word_wr    = 1'b0;
    swap       = 1'b0;
    flush_done = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) begin
          ptr_clr   = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        // Restart beats a commit, which beats a word arriving in the same cycle.
        if (load_start) begin
          ptr_clr = 1'b1;
        end else if (commit) begin
          err_set   = 1'b1;
          state_nxt = IDLE;
        end else if (cw_valid) begin
          word_wr = 1'b1;
          if (wr_ptr == LAST_PTR) state_nxt = ARMED;
        end
      end
      ARMED: begin
        if (load_start) begin
          ptr_clr   = 1'b1;
          state_nxt = LOAD;
        end else if (commit) begin
          state_nxt = SWAP_WAIT;
        end
      end
      SWAP_WAIT: begin
        if (sam_clk_en) begin
          swap      = 1'b1;
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        // The strobe that takes the counter from 1 to 0 is the FLUSH_LEN-th
        // strobe counted from the swap strobe.
        if (sam_clk_en && (flush_cnt <= FW'(1))) begin
          flush_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shadow write pointer.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset)        wr_ptr <= '0;
    else if (ptr_clr) wr_ptr <= '0;
    else if (word_wr) wr_ptr <= wr_ptr + PW'(1);
  end

  // Flush strobe counter.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset)                                flush_cnt <= '0;
    else if (swap)                            flush_cnt <= FLUSH_INIT;
    else if (flush_done)                      flush_cnt <= '0;
    else if (state == FLUSH && sam_clk_en)    flush_cnt <= flush_cnt - FW'(1);
  end

  // Active bank select, output-valid flag and sticky load error.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      bank_sel <= 1'b0;
      y_valid  <= 1'b0;
      load_err <= 1'b0;
    end else begin
      if (swap) begin
        bank_sel <= ~bank_sel;
        y_valid  <= 1'b0;
      end
      if (flush_done) y_valid <= 1'b1;
      if (err_set)      load_err <= 1'b1;
      else if (ptr_clr) load_err <= 1'b0;
    end
  end

  // Coefficient banks; only the shadow bank (not bank_sel) is ever written.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCOEF; i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
    end else if (word_wr) begin
      if (bank_sel) bank0[wr_idx] <= cw_data;
      else          bank1[wr_idx] <= cw_data;
    end
  end

  // Registered filter-side read from the bank active in the read cycle.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset)            coef_rd_data <= '0;
    else if (!rd_in_range) coef_rd_data <= '0;
    else if (bank_sel)    coef_rd_data <= bank1[rd_idx];
    else                  coef_rd_data <= bank0[rd_idx];
  end

endmodule

// File: tb/tb_gsm_coef_ctrl.sv
// Self-checking bench for gsm_coef_ctrl: reset checks, a table of single-cycle
// control vectors, directed multi-cycle sequences, and a randomized run scored
// against a transaction-level reference model.
module tb_gsm_coef_ctrl;

  localparam int WIDTH     = 18;
  localparam int NCOEF     = 51;
  localparam int FLUSH_LEN = 110;

  logic                    sys_clk      = 1'b0;
  logic                    reset        = 1'b1;
  logic                    sam_clk_en   = 1'b0;
  logic                    load_start   = 1'b0;
  logic                    cw_valid     = 1'b0;
  logic                    commit       = 1'b0;
  logic signed [WIDTH-1:0] cw_data      = '0;
  logic [5:0]              coef_rd_addr = '0;
  logic                    cw_ready;
  logic signed [WIDTH-1:0] coef_rd_data;
  logic                    bank_sel;
  logic                    y_valid;
  logic                    busy;
  logic                    load_err;
  logic [2:0]              state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] exp_q[$];

  gsm_coef_ctrl #(.WIDTH(WIDTH), .NCOEF(NCOEF), .FLUSH_LEN(FLUSH_LEN)) dut (
    .sys_clk      (sys_clk),
    .reset        (reset),
    .sam_clk_en   (sam_clk_en),
    .load_start   (load_start),
    .cw_valid     (cw_valid),
    .cw_ready     (cw_ready),
    .cw_data      (cw_data),
    .commit       (commit),
    .coef_rd_addr (coef_rd_addr),
    .coef_rd_data (coef_rd_data),
    .bank_sel     (bank_sel),
    .y_valid      (y_valid),
    .busy         (busy),
    .load_err     (load_err),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 sys_clk = ~sys_clk;

  // ---------------- reference model ----------------
  // Tracks the load as a queue of accepted words, and the flush as a count of
  // strobes since the swap; the shadow bank is filled from the queue at swap.
  logic signed [WIDTH-1:0] m_bank [2][NCOEF];
  logic signed [WIDTH-1:0] m_q[$];
  logic signed [WIDTH-1:0] m_rd;
  bit m_sel, m_yv, m_err, m_loading, m_armed, m_pend, m_flush;
  int m_strobes;

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < NCOEF; i++) m_bank[b][i] = '0;
    m_q.delete();
    m_rd = '0; m_sel = 0; m_yv = 0; m_err = 0;
    m_loading = 0; m_armed = 0; m_pend = 0; m_flush = 0; m_strobes = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic signed [WIDTH-1:0] rd_nxt;
    rd_nxt = '0;
    if (coef_rd_addr < NCOEF) rd_nxt = m_bank[m_sel][coef_rd_addr];
    if (m_loading) begin
      if (load_start) m_q.delete();
      else if (commit) begin m_err = 1; m_loading = 0; end
      else if (cw_valid) begin
        m_q.push_back(cw_data);
        if (m_q.size() == NCOEF) begin m_loading = 0; m_armed = 1; end
      end
    end else if (m_armed) begin
      if (load_start) begin m_armed = 0; m_loading = 1; m_q.delete(); m_err = 0; end
      else if (commit) begin m_armed = 0; m_pend = 1; end
    end else if (m_pend) begin
      if (sam_clk_en) begin
        for (int i = 0; i < NCOEF; i++) m_bank[!m_sel][i] = m_q[i];
        m_sel = !m_sel; m_yv = 0; m_pend = 0; m_flush = 1; m_strobes = 1;
      end
    end else if (m_flush) begin
      if (sam_clk_en) begin
        m_strobes++;
        if (m_strobes == FLUSH_LEN) begin m_yv = 1; m_flush = 0; end
      end
    end else if (load_start) begin
      m_loading = 1; m_q.delete(); m_err = 0;
    end
    m_rd = rd_nxt;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge sys_clk); #1;
  endtask

  task automatic clear_in();
    load_start = 0; cw_valid = 0; commit = 0; sam_clk_en = 0; cw_data = '0;
  endtask

  task automatic do_reset();
    clear_in();
    reset = 1'b1;
    @(posedge sys_clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Control outputs packed as {cw_ready, busy, load_err, bank_sel, y_valid}.
  task automatic check_ctl(input string name, input logic [4:0] exp);
    check(name, {27'd0, cw_ready, busy, load_err, bank_sel, y_valid}, {27'd0, exp});
  endtask

  // Word k of the load is base + incr*k; load_start pulses first.
  task automatic load_words(input int n, input int base, input int incr);
    load_start = 1; step(); load_start = 0;
    for (int k = 0; k < n; k++) begin
      cw_valid = 1; cw_data = WIDTH'(base + incr * k); step();
    end
    cw_valid = 0;
  endtask

  task automatic run_strobes(input int n);
    for (int i = 0; i < n; i++) begin sam_clk_en = 1; step(); end
    sam_clk_en = 0;
  endtask

  task automatic read_check(input string name, input int addr, input int exp);
    coef_rd_addr = 6'(addr);
    exp_q.push_back(WIDTH'(exp));
    step();
    check(name, 32'(coef_rd_data), 32'($signed(exp_q.pop_front())));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic ls, cv, cm, se;
    logic [WIDTH-1:0] d;
    logic [5:0] a;
    logic [4:0] e_ctl;  // {cw_ready, busy, load_err, bank_sel, y_valid}
  } vec_t;

  vec_t vt[12];

  task automatic mk(input int i, input logic ls, input logic cv, input logic cm,
                    input logic se, input int d, input int a, input logic [4:0] e);
    vt[i].ls = ls; vt[i].cv = cv; vt[i].cm = cm; vt[i].se = se;
    vt[i].d = WIDTH'(d); vt[i].a = 6'(a); vt[i].e_ctl = e;
  endtask

  // ---------------- main test ----------------
  initial begin
    int idle;

    // Reset state while reset is held.
    model_reset();
    #2;
    check_ctl("reset_ctl", 5'b00000);
    check("reset_data", 32'(coef_rd_data), 32'd0);
    step(); step();
    reset = 1'b0;

    // Table: single-cycle control behaviour from IDLE through LOAD aborts.
    mk(0,  0,0,0,0, 0, 0,  5'b00000);
    mk(1,  1,0,0,0, 0, 1,  5'b11000);
    mk(2,  0,1,0,0, 1, 2,  5'b11000);
    mk(3,  0,1,0,0, 2, 50, 5'b11000);
    mk(4,  0,0,1,0, 0, 51, 5'b00100);
    mk(5,  0,0,1,0, 0, 63, 5'b00100);
    mk(6,  0,1,0,0, 5, 0,  5'b00100);
    mk(7,  1,0,0,0, 0, 3,  5'b11000);
    mk(8,  0,1,1,0, 9, 4,  5'b00100);
    mk(9,  1,0,0,0, 0, 5,  5'b11000);
    mk(10, 1,1,0,0, 7, 6,  5'b11000);
    mk(11, 0,0,0,1, 0, 7,  5'b11000);
    for (int i = 0; i < 12; i++) begin
      load_start = vt[i].ls; cw_valid = vt[i].cv; commit = vt[i].cm;
      sam_clk_en = vt[i].se; cw_data = vt[i].d; coef_rd_addr = vt[i].a;
      step();
      check_ctl($sformatf("vec%0d_ctl", i), vt[i].e_ctl);
      check($sformatf("vec%0d_data", i), 32'(coef_rd_data), 32'd0);
    end
    clear_in();

    // Full load k->100+k, commit, strobe every 4 cycles.
    do_reset();
    load_words(NCOEF, 100, 1);
    check_ctl("A_armed", 5'b01000);
    commit = 1; step(); commit = 0;
    check_ctl("A_swap_wait", 5'b01000);
    for (int i = 1; i <= FLUSH_LEN; i++) begin
      sam_clk_en = 1; step(); sam_clk_en = 0;
      if (i == 1)         check_ctl("A_first_strobe", 5'b01010);
      if (i == FLUSH_LEN - 1) check_ctl("A_strobe109", 5'b01010);
      if (i == FLUSH_LEN) check_ctl("A_strobe110", 5'b00011);
      repeat (3) step();
    end
    read_check("A_rd50", 50, 150);
    read_check("A_rd0", 0, 100);
    read_check("A_rd25", 25, 125);
    read_check("A_rd51", 51, 0);
    read_check("A_rd63", 63, 0);

    // Partial load, commit -> error; load_start clears it.
    do_reset();
    load_words(30, 1, 1);
    commit = 1; step(); commit = 0;
    check_ctl("B_err", 5'b00100);
    load_start = 1; step(); load_start = 0;
    check_ctl("B_clear", 5'b11000);

    // Aborted load of 20 words then full reload of 7s.
    do_reset();
    load_words(20, 3, 0);
    load_words(NCOEF, 7, 0);
    check_ctl("C_armed", 5'b01000);
    commit = 1; step(); commit = 0;
    run_strobes(FLUSH_LEN);
    check_ctl("C_done", 5'b00011);
    for (int a = 0; a < NCOEF; a++) read_check($sformatf("C_rd%0d", a), a, 7);

    // Continuous read of address 5 across a swap from 1s to 2s.
    do_reset();
    load_words(NCOEF, 1, 0);
    commit = 1; step(); commit = 0;
    run_strobes(FLUSH_LEN);
    load_words(NCOEF, 2, 0);
    coef_rd_addr = 6'd5;
    commit = 1; step(); commit = 0;
    step();
    check("D_pre", 32'(coef_rd_data), 32'd1);
    sam_clk_en = 1; step(); sam_clk_en = 0;
    check("D_swap_plus1", 32'(coef_rd_data), 32'd1);
    check_ctl("D_sel", 5'b01000);
    step();
    check("D_swap_plus2", 32'(coef_rd_data), 32'd2);
    step();
    check("D_swap_plus3", 32'(coef_rd_data), 32'd2);

    // Commit coincident with a strobe; noise on inputs during flush.
    do_reset();
    load_words(NCOEF, 0, 1);
    commit = 1; sam_clk_en = 1; step(); commit = 0; sam_clk_en = 0;
    check_ctl("E_coincident", 5'b01000);
    step();
    check_ctl("E_wait", 5'b01000);
    sam_clk_en = 1; step(); sam_clk_en = 0;
    check_ctl("E_swapped", 5'b01010);
    for (int i = 1; i < FLUSH_LEN; i++) begin
      sam_clk_en = 1; cw_valid = 1'(i & 1); cw_data = WIDTH'(999);
      load_start = (i % 7 == 3); commit = (i % 5 == 0);
      step();
      if (i < FLUSH_LEN - 1) begin
        if (cw_ready !== 1'b0 || busy !== 1'b1) check_ctl($sformatf("E_flush%0d", i), 5'b01010);
      end else begin
        check_ctl("E_done", 5'b00011);
      end
    end
    clear_in();
    read_check("E_rd7", 7, 7);

    // Asynchronous reset mid-flush, then strobes without a load.
    do_reset();
    load_words(NCOEF, 500, 1);
    coef_rd_addr = 6'd3;
    commit = 1; step(); commit = 0;
    run_strobes(1 + 69);
    check("F_pre_data", 32'(coef_rd_data), 32'd503);
    check_ctl("F_pre_ctl", 5'b01010);
    #3 reset = 1'b1;
    #1;
    check_ctl("F_async_ctl", 5'b00000);
    check("F_async_data", 32'(coef_rd_data), 32'd0);
    @(posedge sys_clk); #1;
    reset = 1'b0;
    model_reset();
    run_strobes(FLUSH_LEN + 10);
    check_ctl("F_after", 5'b00000);

    // Randomized run against the reference model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      idle = !(m_loading || m_armed || m_pend || m_flush);
      if (idle)           load_start = ($urandom_range(0, 3) == 0);
      else if (m_armed)   load_start = ($urandom_range(0, 19) == 0);
      else if (m_loading) load_start = ($urandom_range(0, 399) == 0);
      else                load_start = ($urandom_range(0, 9) == 0);
      commit       = m_loading ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 5) == 0);
      cw_valid     = ($urandom_range(0, 3) != 0);
      cw_data      = WIDTH'($urandom);
      sam_clk_en   = 1'($urandom_range(0, 1));
      coef_rd_addr = 6'($urandom_range(0, 63));
      model_step();
      step();
      check_ctl($sformatf("rnd%0d_ctl", c),
                {m_loading, (m_loading | m_armed | m_pend | m_flush), m_err, m_sel, m_yv});
      check($sformatf("rnd%0d_data", c), 32'(coef_rd_data), 32'(m_rd));
    end
    clear_in();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
